hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the 16-bit 5-stage CPU. Drives the stall, flush and hold

---
 rtl/hazard_ctrl.sv | 129 ++++++++++++
 tb/tb_hazard_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: stall/flush/hold control and
// SRAM arbitration between instruction fetch and MEM stage.
module hazard_ctrl #(
  parameter int         MEM_LAT = 1,
  parameter logic [3:0] NOREG   = 4'b1111
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] id_rreg1,
  input  logic [3:0] id_rreg2,
  input  logic [3:0] exe_wreg,
  input  logic [1:0] exe_controlmem,
  input  logic [1:0] mem_controlmem,
  input  logic       branch_taken,
  output logic       pc_stall,
  output logic       ifid_stall,
  output logic       ifid_flush,
  output logic       idClear,
  output logic       pipe_hold,
  output logic       mem_grant_data
);

  localparam int CW =
    (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]    state;
  logic [0:0]    state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic          req;
  logic          load_use;
  logic          cnt_zero;

  assign req =
    (mem_controlmem == 2'b00) ||
    (mem_controlmem == 2'b01);

  assign load_use =
    (exe_controlmem == 2'b00) &&
    (exe_wreg != NOREG) &&
    ((exe_wreg == id_rreg1) ||
     (exe_wreg == id_rreg2));

  assign cnt_zero = (cnt == '0);

  always_comb begin
    pc_stall       = 1'b0;
    ifid_stall     = 1'b0;
    ifid_flush     = 1'b0;
    idClear        = 1'b0;
    pipe_hold      = 1'b0;
    mem_grant_data = 1'b0;
    if (rst) begin
      ifid_flush = 1'b1;
      idClear    = 1'b1;
    end else begin
      case (state)
        WAIT: begin
          mem_grant_data = 1'b1;
          if (!cnt_zero) begin
            pipe_hold = 1'b1;
          end else begin
            pc_stall   = 1'b1;
            ifid_flush = 1'b1;
          end
        end
        default: begin
          if (req) begin
            mem_grant_data = 1'b1;
            if (MEM_LAT == 1) begin
              pc_stall   = 1'b1;
              ifid_flush = 1'b1;
            end else begin
              pipe_hold = 1'b1;
            end
          end
        end
      endcase
      // stage rules layer over the mem rules once unfrozen
      if (!pipe_hold) begin
        if (branch_taken) begin
          ifid_flush = 1'b1;
          idClear    = 1'b1;
          pc_stall   = 1'b0;
          ifid_stall = 1'b0;
        end else if (load_use) begin
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
          idClear    = 1'b1;
          ifid_flush = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      WAIT: begin
        if (cnt_zero) begin
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      default: begin
        if (req && (MEM_LAT > 1)) begin
          state_nx = WAIT;
          cnt_nx   = CW'(MEM_LAT - 2);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three instances (MEM_LAT 1/3/4)
// driven in lockstep, table rows plus multi-cycle sequences.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] id_rreg1;
  logic [3:0] id_rreg2;
  logic [3:0] exe_wreg;
  logic [1:0] exe_controlmem;
  logic [1:0] mem_controlmem;
  logic       branch_taken;

  logic [5:0] o1;
  logic [5:0] o3;
  logic [5:0] o4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // {pc_stall, ifid_stall, ifid_flush, idClear, pipe_hold, grant}
  localparam logic [5:0] RSTV = 6'b001100;
  localparam logic [5:0] NONE = 6'b000000;
  localparam logic [5:0] LU   = 6'b110100;
  localparam logic [5:0] BR   = 6'b001100;
  localparam logic [5:0] MEM1 = 6'b101001;
  localparam logic [5:0] HOLD = 6'b000011;
  localparam logic [5:0] REL  = 6'b101001;
  localparam logic [5:0] LUM  = 6'b110101;
  localparam logic [5:0] BRM  = 6'b001101;

  hazard_ctrl #(.MEM_LAT(1)) u1 (
    .clk(clk), .rst(rst),
    .id_rreg1(id_rreg1), .id_rreg2(id_rreg2),
    .exe_wreg(exe_wreg),
    .exe_controlmem(exe_controlmem),
    .mem_controlmem(mem_controlmem),
    .branch_taken(branch_taken),
    .pc_stall(o1[5]), .ifid_stall(o1[4]),
    .ifid_flush(o1[3]), .idClear(o1[2]),
    .pipe_hold(o1[1]), .mem_grant_data(o1[0])
  );

  hazard_ctrl #(.MEM_LAT(3)) u3 (
    .clk(clk), .rst(rst),
    .id_rreg1(id_rreg1), .id_rreg2(id_rreg2),
    .exe_wreg(exe_wreg),
    .exe_controlmem(exe_controlmem),
    .mem_controlmem(mem_controlmem),
    .branch_taken(branch_taken),
    .pc_stall(o3[5]), .ifid_stall(o3[4]),
    .ifid_flush(o3[3]), .idClear(o3[2]),
    .pipe_hold(o3[1]), .mem_grant_data(o3[0])
  );

  hazard_ctrl #(.MEM_LAT(4)) u4 (
    .clk(clk), .rst(rst),
    .id_rreg1(id_rreg1), .id_rreg2(id_rreg2),
    .exe_wreg(exe_wreg),
    .exe_controlmem(exe_controlmem),
    .mem_controlmem(mem_controlmem),
    .branch_taken(branch_taken),
    .pc_stall(o4[5]), .ifid_stall(o4[4]),
    .ifid_flush(o4[3]), .idClear(o4[2]),
    .pipe_hold(o4[1]), .mem_grant_data(o4[0])
  );

  typedef struct {
    logic       rs;
    logic [3:0] r1;
    logic [3:0] r2;
    logic [3:0] wr;
    logic [1:0] ec;
    logic [1:0] mc;
    logic       br;
    logic [5:0] e1;
    logic [5:0] e3;
    logic [5:0] e4;
  } vec_t;

  typedef struct {
    int         id;
    logic [5:0] e1;
    logic [5:0] e3;
    logic [5:0] e4;
  } exp_t;

  exp_t sb[$];
  int   step_no = 0;

  task automatic cmp(input int id, input string nm,
                     input logic [5:0] got,
                     input logic [5:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL step%0d %s got=%b want=%b",
               id, nm, got, want);
    end
  endtask

  task automatic step(input vec_t v);
    exp_t e;
    rst            = v.rs;
    id_rreg1       = v.r1;
    id_rreg2       = v.r2;
    exe_wreg       = v.wr;
    exe_controlmem = v.ec;
    mem_controlmem = v.mc;
    branch_taken   = v.br;
    sb.push_back('{step_no, v.e1, v.e3, v.e4});
    step_no++;
    @(negedge clk);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard empty");
    end else begin
      e = sb.pop_front();
      cmp(e.id, "lat1", o1, e.e1);
      cmp(e.id, "lat3", o3, e.e3);
      cmp(e.id, "lat4", o4, e.e4);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(
    input logic rs, input logic [3:0] r1,
    input logic [3:0] r2, input logic [3:0] wr,
    input logic [1:0] ec, input logic [1:0] mc,
    input logic br, input logic [5:0] e1,
    input logic [5:0] e3, input logic [5:0] e4);
    vec_t v;
    v.rs = rs; v.r1 = r1; v.r2 = r2; v.wr = wr;
    v.ec = ec; v.mc = mc; v.br = br;
    v.e1 = e1; v.e3 = e3; v.e4 = e4;
    return v;
  endfunction

  vec_t tbl[12];

  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk(1, 0, 1, 2, 2'b11, 2'b11, 0, RSTV, RSTV, RSTV);
    tbl[1]  = mk(1, 0, 1, 2, 2'b11, 2'b11, 0, RSTV, RSTV, RSTV);
    tbl[2]  = mk(0, 0, 1, 2, 2'b00, 2'b11, 0, NONE, NONE, NONE);
    tbl[3]  = mk(0, 3, 4, 3, 2'b00, 2'b11, 0, LU, LU, LU);
    tbl[4]  = mk(0, 3, 4, 15, 2'b11, 2'b11, 0, NONE, NONE, NONE);
    tbl[5]  = mk(0, 15, 15, 15, 2'b00, 2'b11, 0, NONE, NONE, NONE);
    tbl[6]  = mk(0, 1, 5, 5, 2'b00, 2'b11, 0, LU, LU, LU);
    tbl[7]  = mk(0, 3, 4, 3, 2'b01, 2'b11, 0, NONE, NONE, NONE);
    tbl[8]  = mk(0, 15, 4, 3, 2'b00, 2'b11, 0, NONE, NONE, NONE);
    tbl[9]  = mk(0, 3, 4, 3, 2'b00, 2'b11, 1, BR, BR, BR);
    tbl[10] = mk(0, 0, 1, 2, 2'b11, 2'b11, 1, BR, BR, BR);
    tbl[11] = mk(0, 7, 7, 7, 2'b00, 2'b10, 0, LU, LU, LU);

    for (int i = 0; i < 12; i++) step(tbl[i]);
    step(mk(0, 0, 1, 2, 2'b11, 2'b11, 0, NONE, NONE, NONE));

    // store in MEM with concurrent load-use
    step(mk(0, 3, 4, 3, 2'b00, 2'b01, 0, LUM, HOLD, HOLD));
    step(mk(0, 0, 1, 15, 2'b11, 2'b11, 0, NONE, HOLD, HOLD));
    step(mk(0, 0, 1, 15, 2'b11, 2'b11, 0, NONE, REL, HOLD));
    step(mk(0, 0, 1, 15, 2'b11, 2'b11, 0, NONE, NONE, REL));
    step(mk(0, 0, 1, 15, 2'b11, 2'b11, 0, NONE, NONE, NONE));

    // load held in MEM; request ignored while waiting
    step(mk(0, 0, 1, 15, 2'b11, 2'b00, 0, MEM1, HOLD, HOLD));
    step(mk(0, 0, 1, 15, 2'b11, 2'b00, 0, MEM1, HOLD, HOLD));
    step(mk(0, 0, 1, 15, 2'b11, 2'b00, 0, MEM1, REL, HOLD));
    step(mk(0, 0, 1, 15, 2'b11, 2'b11, 0, NONE, NONE, REL));
    step(mk(0, 0, 1, 15, 2'b11, 2'b11, 0, NONE, NONE, NONE));

    // branch + load-use + request; branch frozen during hold
    step(mk(0, 3, 4, 3, 2'b00, 2'b01, 1, BRM, HOLD, HOLD));
    step(mk(0, 3, 4, 3, 2'b00, 2'b01, 1, BRM, HOLD, HOLD));
    step(mk(0, 3, 4, 3, 2'b00, 2'b01, 1, BRM, BRM, HOLD));
    step(mk(0, 3, 4, 3, 2'b00, 2'b11, 1, BR, BR, BRM));
    step(mk(0, 0, 1, 15, 2'b11, 2'b11, 0, NONE, NONE, NONE));

    // reset during the second wait cycle of MEM_LAT=4
    step(mk(0, 0, 1, 15, 2'b11, 2'b00, 0, MEM1, HOLD, HOLD));
    step(mk(1, 0, 1, 15, 2'b11, 2'b00, 0, RSTV, RSTV, RSTV));
    step(mk(0, 0, 1, 15, 2'b11, 2'b11, 0, NONE, NONE, NONE));
    step(mk(0, 0, 1, 15, 2'b11, 2'b11, 0, NONE, NONE, NONE));

    // release cycle with load-use overlaid
    step(mk(0, 0, 1, 15, 2'b11, 2'b01, 0, MEM1, HOLD, HOLD));
    step(mk(0, 0, 1, 15, 2'b11, 2'b11, 0, NONE, HOLD, HOLD));
    step(mk(0, 6, 1, 6, 2'b00, 2'b11, 0, LU, LUM, HOLD));
    step(mk(0, 6, 1, 6, 2'b00, 2'b11, 0, LU, LU, LUM));
    step(mk(0, 0, 1, 15, 2'b11, 2'b11, 0, NONE, NONE, NONE));

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard leftover=%0d want=0",
               sb.size());
    end
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
